// File: rtl/mips_pkg.sv
// MIPS-I encoding constants, field positions and control-decode helpers
// shared by the instruction decode stage.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam int REG_AW  = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_AW-1:0] REG_RA   = 5'd31;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int TARGET_MSB = 25;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic alu_src;
    logic branch;
    logic bne;
    logic jump;
    logic link;
    logic illegal;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE: c.reg_write = 1'b1;
      OP_LW: begin
        c.reg_write = 1'b1;
        c.mem_read  = 1'b1;
        c.alu_src   = 1'b1;
      end
      OP_SW: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      OP_BEQ: c.branch = 1'b1;
      OP_BNE: begin
        c.branch = 1'b1;
        c.bne    = 1'b1;
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      OP_J: c.jump = 1'b1;
      OP_JAL: begin
        c.jump      = 1'b1;
        c.link      = 1'b1;
        c.reg_write = 1'b1;
      end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  // Source usage only matters for hazard detection; unused fields never stall.
  function automatic logic uses_rs(input logic [5:0] opcode);
    return !(opcode == OP_J || opcode == OP_JAL || opcode == OP_LUI);
  endfunction

  function automatic logic uses_rt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE || opcode == OP_SW ||
            opcode == OP_BEQ   || opcode == OP_BNE);
  endfunction

endpackage

// File: rtl/instruction_decode_if.sv
// Bundles the fetch inputs, writeback port and registered ID/EX outputs
// of the decode stage.
interface instruction_decode_if #(
  parameter int DATA_W = 32
);
  import mips_pkg::*;

  logic [INSTR_W-1:0] if_instr;
  logic [INSTR_W-1:0] if_pc;
  logic               flush;
  logic               wb_en;
  logic [REG_AW-1:0]  wb_addr;
  logic [DATA_W-1:0]  wb_data;

  logic               stall;
  logic               id_valid;
  logic [INSTR_W-1:0] id_pc;
  logic [5:0]         id_opcode;
  logic [5:0]         id_funct;
  logic [REG_AW-1:0]  id_rs;
  logic [REG_AW-1:0]  id_rt;
  logic [REG_AW-1:0]  id_shamt;
  logic [REG_AW-1:0]  id_wr_addr;
  logic [INSTR_W-1:0] id_imm;
  logic [DATA_W-1:0]  id_rs_data;
  logic [DATA_W-1:0]  id_rt_data;
  logic [INSTR_W-1:0] id_jtarget;
  logic               id_reg_write;
  logic               id_mem_read;
  logic               id_mem_write;
  logic               id_alu_src;
  logic               id_branch;
  logic               id_bne;
  logic               id_jump;
  logic               id_link;
  logic               id_illegal;

  modport master (
    output if_instr, if_pc, flush, wb_en, wb_addr, wb_data,
    input  stall, id_valid, id_pc, id_opcode, id_funct, id_rs, id_rt,
           id_shamt, id_wr_addr, id_imm, id_rs_data, id_rt_data, id_jtarget,
           id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_branch,
           id_bne, id_jump, id_link, id_illegal
  );

  modport slave (
    input  if_instr, if_pc, flush, wb_en, wb_addr, wb_data,
    output stall, id_valid, id_pc, id_opcode, id_funct, id_rs, id_rt,
           id_shamt, id_wr_addr, id_imm, id_rs_data, id_rt_data, id_jtarget,
           id_reg_write, id_mem_read, id_mem_write, id_alu_src, id_branch,
           id_bne, id_jump, id_link, id_illegal
  );

endinterface

// File: rtl/register_file.sv
// Two-read, one-write register file with $0 hardwired to zero and
// write-through bypass so a same-cycle writeback is visible to the reader.
module register_file #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32,
  parameter int ADDR_W  = $clog2(REG_CNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [REG_CNT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && wr_addr != '0) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_a = regs[rd_addr_a];
    if (rd_addr_a == '0) begin
      rd_data_a = '0;
    end else if (wr_en && wr_addr == rd_addr_a) begin
      rd_data_a = wr_data;
    end
  end

  always_comb begin
    rd_data_b = regs[rd_addr_b];
    if (rd_addr_b == '0) begin
      rd_data_b = '0;
    end else if (wr_en && wr_addr == rd_addr_b) begin
      rd_data_b = wr_data;
    end
  end

endmodule

// File: rtl/instruction_decode.sv
// MIPS-I decode stage: IF/ID register, field split, register-file read,
// control generation, ID/EX register and load-use stall detection.
module instruction_decode #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32
) (
  input logic                 clk,
  input logic                 rst,
  instruction_decode_if.slave bus
);
  import mips_pkg::*;

  logic               ifid_valid;
  logic [INSTR_W-1:0] ifid_instr;
  logic [INSTR_W-1:0] ifid_pc;

  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic [REG_AW-1:0]  rs;
  logic [REG_AW-1:0]  rt;
  logic [REG_AW-1:0]  rd;
  logic [REG_AW-1:0]  shamt;
  logic [15:0]        imm16;
  logic [25:0]        target;

  ctrl_t              ctrl;
  logic [REG_AW-1:0]  wr_addr;
  logic [INSTR_W-1:0] imm_ext;
  logic [INSTR_W-1:0] jtarget;
  logic [DATA_W-1:0]  rs_data;
  logic [DATA_W-1:0]  rt_data;
  logic               load_use;

  assign opcode = ifid_instr[OPCODE_MSB:OPCODE_LSB];
  assign rs     = ifid_instr[RS_MSB:RS_LSB];
  assign rt     = ifid_instr[RT_MSB:RT_LSB];
  assign rd     = ifid_instr[RD_MSB:RD_LSB];
  assign shamt  = ifid_instr[SHAMT_MSB:SHAMT_LSB];
  assign funct  = ifid_instr[FUNCT_MSB:FUNCT_LSB];
  assign imm16  = ifid_instr[IMM_MSB:0];
  assign target = ifid_instr[TARGET_MSB:0];

  assign ctrl    = decode_ctrl(opcode);
  assign jtarget = ((ifid_pc + 32'd4) & 32'hF000_0000) | {4'b0000, target, 2'b00};

  // andi/ori are logical ops and take a zero-extended immediate.
  always_comb begin
    imm_ext = {{16{imm16[15]}}, imm16};
    if (opcode == OP_ANDI || opcode == OP_ORI) begin
      imm_ext = {16'h0000, imm16};
    end
  end

  always_comb begin
    wr_addr = rt;
    if (opcode == OP_RTYPE) begin
      wr_addr = rd;
    end else if (opcode == OP_JAL) begin
      wr_addr = REG_RA;
    end
  end

  register_file #(
    .DATA_W  (DATA_W),
    .REG_CNT (REG_CNT),
    .ADDR_W  (REG_AW)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (rs),
    .rd_addr_b (rt),
    .rd_data_a (rs_data),
    .rd_data_b (rt_data),
    .wr_en     (bus.wb_en),
    .wr_addr   (bus.wb_addr),
    .wr_data   (bus.wb_data)
  );

  // The load in EX has no data until MEM, so a dependent instruction in ID waits one cycle.
  always_comb begin
    load_use = 1'b0;
    if (ifid_valid && bus.id_valid && bus.id_mem_read && bus.id_wr_addr != REG_ZERO) begin
      if (uses_rs(opcode) && rs == bus.id_wr_addr) begin
        load_use = 1'b1;
      end
      if (uses_rt(opcode) && rt == bus.id_wr_addr) begin
        load_use = 1'b1;
      end
    end
  end

  assign bus.stall = load_use && !bus.flush && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      ifid_pc    <= '0;
    end else if (bus.flush) begin
      ifid_valid <= 1'b0;
    end else if (!load_use) begin
      ifid_valid <= 1'b1;
      ifid_instr <= bus.if_instr;
      ifid_pc    <= bus.if_pc;
    end
  end

  // Bubbles are fully zeroed so a held instruction never issues its side effects twice.
  always_ff @(posedge clk) begin
    if (rst || bus.flush || load_use || !ifid_valid) begin
      bus.id_valid     <= 1'b0;
      bus.id_pc        <= '0;
      bus.id_opcode    <= '0;
      bus.id_funct     <= '0;
      bus.id_rs        <= '0;
      bus.id_rt        <= '0;
      bus.id_shamt     <= '0;
      bus.id_wr_addr   <= '0;
      bus.id_imm       <= '0;
      bus.id_rs_data   <= '0;
      bus.id_rt_data   <= '0;
      bus.id_jtarget   <= '0;
      bus.id_reg_write <= 1'b0;
      bus.id_mem_read  <= 1'b0;
      bus.id_mem_write <= 1'b0;
      bus.id_alu_src   <= 1'b0;
      bus.id_branch    <= 1'b0;
      bus.id_bne       <= 1'b0;
      bus.id_jump      <= 1'b0;
      bus.id_link      <= 1'b0;
      bus.id_illegal   <= 1'b0;
    end else begin
      bus.id_valid     <= 1'b1;
      bus.id_pc        <= ifid_pc;
      bus.id_opcode    <= opcode;
      bus.id_funct     <= funct;
      bus.id_rs        <= rs;
      bus.id_rt        <= rt;
      bus.id_shamt     <= shamt;
      bus.id_wr_addr   <= wr_addr;
      bus.id_imm       <= imm_ext;
      bus.id_rs_data   <= rs_data;
      bus.id_rt_data   <= rt_data;
      bus.id_jtarget   <= jtarget;
      bus.id_reg_write <= ctrl.reg_write;
      bus.id_mem_read  <= ctrl.mem_read;
      bus.id_mem_write <= ctrl.mem_write;
      bus.id_alu_src   <= ctrl.alu_src;
      bus.id_branch    <= ctrl.branch;
      bus.id_bne       <= ctrl.bne;
      bus.id_jump      <= ctrl.jump;
      bus.id_link      <= ctrl.link;
      bus.id_illegal   <= ctrl.illegal;
    end
  end

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode: directed pipeline scenarios
// followed by randomized traffic against a transaction-level reference model.
module tb_instruction_decode;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  instruction_decode_if #(.DATA_W(32)) bus ();

  instruction_decode #(
    .DATA_W  (32),
    .REG_CNT (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Flag vector order: reg_write, mem_read, mem_write, alu_src, branch, bne, jump, link, illegal
  typedef struct {
    bit        valid;
    bit [31:0] pc;
    bit [5:0]  opcode;
    bit [5:0]  funct;
    bit [4:0]  rs;
    bit [4:0]  rt;
    bit [4:0]  shamt;
    bit [4:0]  wrAddr;
    bit [31:0] imm;
    bit [31:0] rsData;
    bit [31:0] rtData;
    bit [31:0] jtarget;
    bit [8:0]  flags;
  } exp_t;

  exp_t      expIdex;
  bit        mIfValid;
  bit [31:0] mIfInstr;
  bit [31:0] mIfPc;
  bit [31:0] mRegs [32];

  int numChecks = 0;
  int numPassed = 0;
  bit lastStall;
  bit obsStall;

  bit [5:0] legalOps [12] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08,
                              6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h02, 6'h03};

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numChecks++;
    if (observed === expected) begin
      numPassed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic bit [8:0] refFlags(input bit [5:0] op);
    case (op)
      6'h00:                             return 9'b100000000;
      6'h23:                             return 9'b110100000;
      6'h2B:                             return 9'b001100000;
      6'h04:                             return 9'b000010000;
      6'h05:                             return 9'b000011000;
      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F: return 9'b100100000;
      6'h02:                             return 9'b000000100;
      6'h03:                             return 9'b100000110;
      default:                           return 9'b000000001;
    endcase
  endfunction

  function automatic bit [31:0] readReg(input bit [4:0] a, input bit wbEn,
                                        input bit [4:0] wbAddr, input bit [31:0] wbData);
    if (a == 0) return 32'h0;
    if (wbEn && wbAddr == a) return wbData;
    return mRegs[a];
  endfunction

  function automatic exp_t refDecode(input bit [31:0] instr, input bit [31:0] pc,
                                     input bit wbEn, input bit [4:0] wbAddr,
                                     input bit [31:0] wbData);
    exp_t      e;
    bit [5:0]  op;
    bit [31:0] tgt;
    op       = instr[31:26];
    e.valid  = 1'b1;
    e.pc     = pc;
    e.opcode = op;
    e.funct  = instr[5:0];
    e.rs     = instr[25:21];
    e.rt     = instr[20:16];
    e.shamt  = instr[10:6];
    e.flags  = refFlags(op);
    if (op == 6'h00)      e.wrAddr = instr[15:11];
    else if (op == 6'h03) e.wrAddr = 5'd31;
    else                  e.wrAddr = instr[20:16];
    if (op == 6'h0C || op == 6'h0D || !instr[15]) e.imm = 32'(instr[15:0]);
    else                                          e.imm = 32'hFFFF0000 | 32'(instr[15:0]);
    tgt       = 32'(instr[25:0]) * 4;
    e.jtarget = ((pc + 32'd4) & 32'hF0000000) | tgt;
    e.rsData  = readReg(instr[25:21], wbEn, wbAddr, wbData);
    e.rtData  = readReg(instr[20:16], wbEn, wbAddr, wbData);
    return e;
  endfunction

  function automatic bit refStall(input bit fl);
    bit [5:0] op;
    bit       readsRs;
    bit       readsRt;
    if (rst || fl || !mIfValid || !expIdex.valid) return 1'b0;
    if (!expIdex.flags[7] || expIdex.wrAddr == 0) return 1'b0;
    op      = mIfInstr[31:26];
    readsRs = !(op inside {6'h02, 6'h03, 6'h0F});
    readsRt = op inside {6'h00, 6'h2B, 6'h04, 6'h05};
    return (readsRs && mIfInstr[25:21] == expIdex.wrAddr) ||
           (readsRt && mIfInstr[20:16] == expIdex.wrAddr);
  endfunction

  task automatic compareIdex();
    bit [8:0] obsFlags;
    obsFlags = {bus.id_reg_write, bus.id_mem_read, bus.id_mem_write, bus.id_alu_src,
                bus.id_branch, bus.id_bne, bus.id_jump, bus.id_link, bus.id_illegal};
    checkOutput("id_valid",   32'(bus.id_valid),   32'(expIdex.valid));
    checkOutput("id_pc",      bus.id_pc,           expIdex.pc);
    checkOutput("id_opcode",  32'(bus.id_opcode),  32'(expIdex.opcode));
    checkOutput("id_funct",   32'(bus.id_funct),   32'(expIdex.funct));
    checkOutput("id_rs",      32'(bus.id_rs),      32'(expIdex.rs));
    checkOutput("id_rt",      32'(bus.id_rt),      32'(expIdex.rt));
    checkOutput("id_shamt",   32'(bus.id_shamt),   32'(expIdex.shamt));
    checkOutput("id_wr_addr", 32'(bus.id_wr_addr), 32'(expIdex.wrAddr));
    checkOutput("id_imm",     bus.id_imm,          expIdex.imm);
    checkOutput("id_rs_data", bus.id_rs_data,      expIdex.rsData);
    checkOutput("id_rt_data", bus.id_rt_data,      expIdex.rtData);
    checkOutput("id_jtarget", bus.id_jtarget,      expIdex.jtarget);
    checkOutput("id_flags",   32'(obsFlags),       32'(expIdex.flags));
  endtask

  // One clock cycle: drive inputs, check stall, advance the model, check ID/EX.
  task automatic applyStimulus(input bit [31:0] instr, input bit [31:0] pc, input bit fl,
                               input bit wbEn, input bit [4:0] wbAddr, input bit [31:0] wbData);
    exp_t nextE;
    bit   expStall;
    bus.if_instr = instr;
    bus.if_pc    = pc;
    bus.flush    = fl;
    bus.wb_en    = wbEn;
    bus.wb_addr  = wbAddr;
    bus.wb_data  = wbData;
    #1;
    expStall  = refStall(fl);
    obsStall  = bus.stall;
    checkOutput("stall", 32'(bus.stall), 32'(expStall));
    lastStall = expStall;
    if (rst) begin
      expIdex  = '{default: '0};
      mIfValid = 1'b0;
      mIfInstr = '0;
      mIfPc    = '0;
      for (int i = 0; i < 32; i++) mRegs[i] = '0;
    end else begin
      nextE = '{default: '0};
      if (!fl && !expStall && mIfValid) nextE = refDecode(mIfInstr, mIfPc, wbEn, wbAddr, wbData);
      if (wbEn && wbAddr != 0) mRegs[wbAddr] = wbData;
      if (fl) begin
        mIfValid = 1'b0;
      end else if (!expStall) begin
        mIfValid = 1'b1;
        mIfInstr = instr;
        mIfPc    = pc;
      end
      expIdex = nextE;
    end
    @(posedge clk);
    #1;
    compareIdex();
    @(negedge clk);
  endtask

  function automatic bit [31:0] randInstr();
    bit [5:0] op;
    if ($urandom_range(0, 3) == 0)      op = 6'h23;
    else if ($urandom_range(0, 9) < 9)  op = legalOps[$urandom_range(0, 11)];
    else                                op = 6'($urandom);
    return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit [31:0] pc;
    bit [31:0] instr;
    rst          = 1'b1;
    bus.if_instr = '0;
    bus.if_pc    = '0;
    bus.flush    = 1'b0;
    bus.wb_en    = 1'b0;
    bus.wb_addr  = '0;
    bus.wb_data  = '0;
    @(negedge clk);
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    applyStimulus(32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 32'h0);
    rst = 1'b0;

    applyStimulus(32'h20080005, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    applyStimulus(32'h00000000, 32'h4, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("tp_addi_valid", 32'(bus.id_valid), 32'd1);
    checkOutput("tp_addi_imm", bus.id_imm, 32'h5);
    checkOutput("tp_addi_wr", 32'(bus.id_wr_addr), 32'd8);
    checkOutput("tp_addi_ctl", 32'({bus.id_reg_write, bus.id_alu_src}), 32'd3);

    applyStimulus(32'h3408FFFF, 32'h8, 1'b0, 1'b0, 5'd0, 32'h0);
    applyStimulus(32'h2008FFFF, 32'hC, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("tp_ori_imm", bus.id_imm, 32'h0000FFFF);
    applyStimulus(32'h00000000, 32'h10, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("tp_addi_neg_imm", bus.id_imm, 32'hFFFFFFFF);

    // lw $9 then add $10,$9,$8: one stall, one bubble, then add with bypassed $9.
    applyStimulus(32'h8D090000, 32'h14, 1'b0, 1'b0, 5'd0, 32'h0);
    applyStimulus(32'h01285020, 32'h18, 1'b0, 1'b0, 5'd0, 32'h0);
    applyStimulus(32'h00000000, 32'h1C, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("tp_lu_stall", 32'(obsStall), 32'd1);
    checkOutput("tp_lu_bubble", 32'(bus.id_valid), 32'd0);
    applyStimulus(32'h00000000, 32'h1C, 1'b0, 1'b1, 5'd9, 32'hDEADBEEF);
    checkOutput("tp_lu_stall_clear", 32'(obsStall), 32'd0);
    checkOutput("tp_add_rs", 32'(bus.id_rs), 32'd9);
    checkOutput("tp_add_rt", 32'(bus.id_rt), 32'd8);
    checkOutput("tp_add_wr", 32'(bus.id_wr_addr), 32'd10);
    checkOutput("tp_add_bypass", bus.id_rs_data, 32'hDEADBEEF);

    applyStimulus(32'h01005020, 32'h20, 1'b0, 1'b0, 5'd0, 32'h0);
    applyStimulus(32'h00000000, 32'h24, 1'b0, 1'b1, 5'd0, 32'h12345678);
    checkOutput("tp_zero_read", bus.id_rs_data, 32'h0);

    applyStimulus(32'h08000040, 32'h10, 1'b0, 1'b0, 5'd0, 32'h0);
    applyStimulus(32'h0C000040, 32'h14, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("tp_j_jump", 32'(bus.id_jump), 32'd1);
    checkOutput("tp_j_target", bus.id_jtarget, 32'h00000100);
    applyStimulus(32'h00000000, 32'h18, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("tp_jal_link", 32'(bus.id_link), 32'd1);
    checkOutput("tp_jal_wr", 32'(bus.id_wr_addr), 32'd31);

    // Flush during a live load-use hazard, then an illegal opcode.
    applyStimulus(32'h8D090000, 32'h40, 1'b0, 1'b0, 5'd0, 32'h0);
    applyStimulus(32'h01285020, 32'h44, 1'b0, 1'b0, 5'd0, 32'h0);
    applyStimulus(32'h00000000, 32'h48, 1'b1, 1'b0, 5'd0, 32'h0);
    checkOutput("tp_flush_stall", 32'(obsStall), 32'd0);
    checkOutput("tp_flush_bubble", 32'(bus.id_valid), 32'd0);
    applyStimulus(32'hFC000000, 32'h80, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("tp_flush_ifid", 32'(bus.id_valid), 32'd0);
    applyStimulus(32'h00000000, 32'h84, 1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("tp_illegal_valid", 32'(bus.id_valid), 32'd1);
    checkOutput("tp_illegal_flags",
                32'({bus.id_reg_write, bus.id_mem_read, bus.id_mem_write, bus.id_alu_src,
                     bus.id_branch, bus.id_bne, bus.id_jump, bus.id_link, bus.id_illegal}),
                32'd1);

    pc    = 32'h1000;
    instr = randInstr();
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst = (cyc == 200);
      applyStimulus(instr, pc, ($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 9)), $urandom);
      if (!lastStall) begin
        pc    = pc + 32'd4;
        instr = randInstr();
      end
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", numPassed, numChecks);
    $finish;
  end

endmodule
